// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: reassembles start-bit framed serial words (MSB first)
// sampled on SerialEn strobes into a one-entry valid/ready holding register.
// Optional even-parity checking is compiled in with `define PARITY_CHECK_EN.
module serial_frame_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SerialIn,
  input  logic             SerialEn,
  input  logic             DataReady,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] DataOut,
  output logic             DataValid,
  output logic             Busy,
  output logic             Overrun,
  output logic             ParityErr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d;

  logic             deliver;
  logic             accept;
  logic [WIDTH-1:0] word;

  // Next-state logic: frame FSM on strobes, handshake and error clearing every edge
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;
    deliver   = 1'b0;
    word      = shift_q;
    accept    = valid_q & DataReady;

    if (accept) begin
      valid_d = 1'b0;
    end

    // clearing happens first so an error raised on the same edge wins
    if (ClearErr) begin
      overrun_d = 1'b0;
      perr_d    = 1'b0;
    end

    if (SerialEn) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (SerialIn) begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_d = {shift_q[WIDTH-2:0], SerialIn};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            deliver = 1'b1;
            word    = shift_d;
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          deliver = 1'b1;
          word    = shift_q;
          if (^{shift_q, SerialIn}) begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // a finished word lands only if the holding slot is free or leaving now
    if (deliver) begin
      if (!valid_q || accept) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset; reset drops any partial frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign DataOut   = data_q;
  assign DataValid = valid_q;
  assign Busy      = (state_q != IDLE);
  assign Overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign ParityErr = perr_q;
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed bench with an expected-word scoreboard
// for serial_frame_receiver (WIDTH=4). Honours `define PARITY_CHECK_EN.
module tb_serial_frame_receiver;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             SerialIn = 1'b0;
  logic             SerialEn = 1'b0;
  logic             DataReady = 1'b0;
  logic             ClearErr = 1'b0;
  logic [WIDTH-1:0] DataOut;
  logic             DataValid;
  logic             Busy;
  logic             Overrun;
  logic             ParityErr;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] expQ[$];

  serial_frame_receiver #(.WIDTH(WIDTH)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .SerialIn(SerialIn),
    .SerialEn(SerialEn),
    .DataReady(DataReady),
    .ClearErr(ClearErr),
    .DataOut(DataOut),
    .DataValid(DataValid),
    .Busy(Busy),
    .Overrun(Overrun),
    .ParityErr(ParityErr)
  );

  // free-running clock, 10 time units per period
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one strobed bit; inputs change 1 unit after the edge
  task automatic strobe(input logic b);
    SerialIn = b;
    SerialEn = 1'b1;
    @(posedge Clk);
    #1;
    SerialEn = 1'b0;
    SerialIn = 1'b0;
  endtask

  task automatic idleCycle();
    SerialEn = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  // full frame: start, data MSB first, optional even parity; gap adds a
  // non-strobe cycle after every strobe; readyLast forces DataReady before
  // the completing strobe when setReady is 1
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input bit gap,
                               input bit setReady, input logic readyLast);
    int nBits;
    logic [WIDTH+1:0] bits;
    bits = '0;
    bits[WIDTH+1] = 1'b1;
    bits[WIDTH:1] = w;
`ifdef PARITY_CHECK_EN
    bits[0] = ^w;
    nBits = WIDTH + 2;
`else
    nBits = WIDTH + 1;
`endif
    for (int i = 0; i < nBits; i++) begin
      if (setReady && i == nBits - 1) DataReady = readyLast;
      strobe(bits[WIDTH+1-i]);
      if (gap && i != nBits - 1) idleCycle();
    end
  endtask

  // pop the next expected word and compare it with what the DUT presents
  task automatic expectWord(input string tag);
    logic [WIDTH-1:0] exp;
    checkOutput({tag, "_valid"}, DataValid, 1);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 0, 1);
    end else begin
      exp = expQ.pop_front();
      checkOutput({tag, "_data"}, DataOut, exp);
    end
  endtask

  initial begin
    $display("[TB] start");
    // reset while the line is busy; reset must win
    SerialEn = 1'b1;
    SerialIn = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    SerialEn = 1'b0;
    SerialIn = 1'b0;
    Reset = 1'b0;
    checkOutput("rstValid", DataValid, 0);
    checkOutput("rstBusy", Busy, 0);
    checkOutput("rstOverrun", Overrun, 0);
    checkOutput("rstParity", ParityErr, 0);
    checkOutput("rstData", DataOut, 0);

    // basic frame 1010
    DataReady = 1'b1;
    expQ.push_back(4'b1010);
    applyStimulus(4'b1010, 0, 0, 1'b1);
    expectWord("basic");
    checkOutput("basicBusy", Busy, 0);
    idleCycle();
    checkOutput("basicAccepted", DataValid, 0);

    // idle zeros never start a frame
    for (int i = 0; i < 10; i++) begin
      strobe(1'b0);
      checkOutput("idleBusy", Busy, 0);
    end
    checkOutput("idleValid", DataValid, 0);

    // strobe every other cycle
    expQ.push_back(4'b0111);
    applyStimulus(4'b0111, 1, 0, 1'b1);
    expectWord("gapped");
    idleCycle();

    // overrun: holding register full, second frame dropped
    DataReady = 1'b0;
    expQ.push_back(4'hA);
    applyStimulus(4'hA, 0, 0, 1'b0);
    expectWord("ovrFirst");
    applyStimulus(4'h5, 0, 0, 1'b0);
    checkOutput("ovrData", DataOut, 4'hA);
    checkOutput("ovrValid", DataValid, 1);
    checkOutput("ovrFlag", Overrun, 1);
    ClearErr = 1'b1;
    idleCycle();
    ClearErr = 1'b0;
    checkOutput("ovrCleared", Overrun, 0);
    checkOutput("ovrHeld", DataOut, 4'hA);
    DataReady = 1'b1;
    idleCycle();
    checkOutput("ovrDrained", DataValid, 0);

    // accept on the completing edge replaces the word without overrun
    DataReady = 1'b0;
    expQ.push_back(4'hA);
    applyStimulus(4'hA, 0, 0, 1'b0);
    expectWord("swapFirst");
    expQ.push_back(4'h5);
    applyStimulus(4'h5, 0, 1, 1'b1);
    expectWord("swapSecond");
    checkOutput("swapOverrun", Overrun, 0);
    idleCycle();
    checkOutput("swapDrained", DataValid, 0);

    // reset after two data bits abandons the frame
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    checkOutput("midBusy", Busy, 1);
    Reset = 1'b1;
    idleCycle();
    Reset = 1'b0;
    checkOutput("midRstBusy", Busy, 0);
    checkOutput("midRstValid", DataValid, 0);
    strobe(1'b0);
    strobe(1'b0);
    checkOutput("midNoSpurious", DataValid, 0);
    expQ.push_back(4'h3);
    applyStimulus(4'h3, 0, 0, 1'b1);
    expectWord("afterRst");

    // back-to-back frames, no idle strobes between them
    expQ.push_back(4'hF);
    expQ.push_back(4'h0);
    expQ.push_back(4'h9);
    applyStimulus(4'hF, 0, 0, 1'b1);
    expectWord("b2bF");
    applyStimulus(4'h0, 0, 0, 1'b1);
    expectWord("b2b0");
    applyStimulus(4'h9, 0, 0, 1'b1);
    expectWord("b2b9");
    idleCycle();
    checkOutput("b2bDrained", DataValid, 0);
    checkOutput("b2bOverrun", Overrun, 0);

`ifdef PARITY_CHECK_EN
    // good parity then bad parity on data 4'hC
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0); strobe(1'b0);
    checkOutput("parGoodData", DataOut, 4'hC);
    checkOutput("parGoodErr", ParityErr, 0);
    idleCycle();
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b0); strobe(1'b1);
    checkOutput("parBadData", DataOut, 4'hC);
    checkOutput("parBadValid", DataValid, 1);
    checkOutput("parBadErr", ParityErr, 1);
    ClearErr = 1'b1;
    idleCycle();
    ClearErr = 1'b0;
    checkOutput("parCleared", ParityErr, 0);
`else
    checkOutput("parTiedOff", ParityErr, 0);
`endif

    checkOutput("sbDrained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Downstream consumer of the 4-bit parallel-in/serial-out shift register stage.
- Samples that stage's serial output (MSB first) on cycles qualified by the same shift-enable strobe.
- Detects a start bit and reassembles WIDTH-bit words into a one-entry holding register.
- Presents each word through a valid/ready handshake, with sticky overrun and, optionally, parity error reporting.

Parameters:
WIDTH, 4, data bits per frame; legal range 2..16.

Ports:
Clk  input  1  system clock; all logic on posedge.
Reset  input  1  synchronous, active-high reset.
SerialIn  input  1  serial data from the upstream stage's ShiftOut, MSB first.
SerialEn  input  1  bit strobe; SerialIn is sampled only on edges where this is 1.
DataReady  input  1  consumer accepts DataOut on an edge where DataValid=1 and DataReady=1.
ClearErr  input  1  clears Overrun and ParityErr.
DataOut  output  WIDTH  holding register contents.
DataValid  output  1  holding register full.
Busy  output  1  1 while a frame is in progress (state not IDLE).
Overrun  output  1  sticky: a completed frame was dropped because the holding register was full.
ParityErr  output  1  sticky parity failure; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE; shift register, bit counter and DataOut all 0.
  - DataValid=0, Busy=0, Overrun=0, ParityErr=0.
  - Reset asserted mid-frame abandons the frame; no partial word is ever delivered.
- All state advances occur only on edges with SerialEn=1, except handshake and ClearErr, which act every edge.
- Frame format: start bit (1), then WIDTH data bits MSB first, then a parity bit only if PARITY_CHECK_EN is defined. An idle line is 0.
- States:
  - IDLE: SerialEn=1 and SerialIn=1 -> SHIFT with counter=0. SerialIn=0 stays in IDLE.
  - SHIFT: each strobe does shift <= {shift[WIDTH-2:0], SerialIn} and counter+1. On the strobe carrying data bit WIDTH-1 (counter==WIDTH-1), go to PARITY if enabled, else deliver and go to IDLE.
  - PARITY: on the strobe, check the parity bit, deliver, then go to IDLE.
- Back-to-back frames are allowed. A start bit may arrive on the strobe immediately after delivery.
- Delivery happens on the completing edge:
  - If the holding register is empty, or is being accepted on that same edge, DataOut <= assembled word and DataValid stays or becomes 1.
  - Otherwise the word is dropped, Overrun <= 1 and DataOut is unchanged.
- Latency: DataValid is visible the cycle after the edge that samples the final bit.
- Handshake:
  - DataValid & DataReady with no delivery on that edge -> DataValid <= 0; DataOut holds its value.
  - DataValid and DataOut are stable until accepted.
- ClearErr: clears Overrun and ParityErr on the edge. If a new error event occurs on the same edge, the set wins.
- Gaps: SerialEn=0 for any number of cycles mid-frame freezes state and counter.
- Counter width is clog2(WIDTH+1). The counter never wraps mid-frame and returns to 0 in IDLE.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - One extra even-parity bit per frame. The bit is correct when XOR(data bits, parity bit)=0.
  - On mismatch, ParityErr <= 1 (sticky). The word is still delivered under normal handshake rules.
  - Frame length is WIDTH+2 strobes.
- Undefined:
  - No PARITY state; frame length is WIDTH+1 strobes.
  - ParityErr is constant 0.

Test Plan:
- Reset, WIDTH=4, DataReady=1, strobes SerialIn=1,1,0,1,0 -> DataValid=1 one cycle after the 5th strobe, DataOut=4'b1010, Busy=0.
- Idle zeros: 10 strobes with SerialIn=0 -> Busy stays 0 and DataValid stays 0. The frame 1,0,1,1,1 with SerialEn toggling 1/0 every cycle -> DataOut=4'b0111.
- DataReady=0; frames carrying 4'hA then 4'h5 -> DataOut=4'hA, Overrun=1. Pulse ClearErr -> Overrun=0. With DataReady=1 on the completing edge of the second frame instead -> DataOut=4'h5, DataValid stays 1, Overrun=0.
- Reset asserted after 2 data bits of a frame, then a full frame carrying 4'h3 -> DataOut=4'h3, with no spurious DataValid before it.
- Back-to-back frames 4'hF, 4'h0, 4'h9 with no idle strobes and DataReady=1 -> three DataValid pulses with DataOut 4'hF, 4'h0, 4'h9 in order.
- PARITY_CHECK_EN defined: frame 1,1,1,0,0,0 (data 4'hC, parity 0) -> ParityErr=0. Frame 1,1,1,0,0,1 -> DataOut=4'hC, ParityErr=1.
